// File: rtl/jh_perm_iter_pkg.sv
// Shared definitions for the iterative JH permutation engine:
// S-box tables, GF(2^4) doubling, width helpers, JH-8 initial constant
// and the engine FSM state type.
package jh_pkg;

  typedef enum logic [1:0] {
    PERM_IDLE,
    PERM_BUSY,
    PERM_DONE
  } perm_state_t;

  localparam logic [3:0] S0_TAB [16] = '{
    4'h9, 4'h0, 4'h4, 4'hB, 4'hD, 4'hC, 4'h3, 4'hF,
    4'h1, 4'hA, 4'h2, 4'h6, 4'h7, 4'h5, 4'h8, 4'hE
  };

  localparam logic [3:0] S1_TAB [16] = '{
    4'h3, 4'hC, 4'h6, 4'hD, 4'h5, 4'h7, 4'h1, 4'h9,
    4'hF, 4'h2, 4'h0, 4'h4, 4'hB, 4'hA, 4'hE, 4'h8
  };

  // Initial round constant C0 of JH-8 (fractional part of sqrt(2)).
  localparam logic [255:0] JH8_C0 =
    256'h6a09e667f3bcc908b2fb1366ea957d3e3adec17512775099da2f590b0667322a;

  // Multiply by x in GF(2^4) modulo x^4 + x + 1.
  function automatic logic [3:0] gf_mul2(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
  endfunction

  // State width in bits for dimension d.
  function automatic int state_w(input int d);
    return 4 * (2 ** d);
  endfunction

  // Round-constant width in bits for dimension d.
  function automatic int const_w(input int d);
    return 2 ** d;
  endfunction

endpackage

// File: rtl/jh_perm_iter_if.sv
// Handshake bundle for jh_perm_iter: start request with state/constant,
// result with backpressure. The abort signal exists only when
// JH_PERM_ABORT_EN is defined.
interface jh_perm_iter_if
  import jh_pkg::*;
#(parameter int D = 6);

  localparam int W  = state_w(D);
  localparam int CW = const_w(D);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_state;
  logic [CW-1:0] in_rc0;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_state;

`ifdef JH_PERM_ABORT_EN
  logic          abort;

  modport master (
    output in_valid, in_state, in_rc0, out_ready, abort,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, in_rc0, out_ready, abort,
    output in_ready, out_valid, out_state
  );
`else
  modport master (
    output in_valid, in_state, in_rc0, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, in_rc0, out_ready,
    output in_ready, out_valid, out_state
  );
`endif

endinterface

// File: rtl/jh_perm_iter_round_core.sv
// Combinational single JH round R_D(A, C): S-box layer chosen per nibble by
// the select bits, linear layer L on nibble pairs, then P_D = phi o P' o pi.
// Nibble 0 sits at the MSBs of din/dout; select bit 0 is the MSB of sel.
module jh_round_core
  import jh_pkg::*;
#(parameter int D = 6)
(
  input  logic [(2**D)-1:0]   sel,
  input  logic [4*(2**D)-1:0] din,
  output logic [4*(2**D)-1:0] dout
);

  localparam int unsigned N = 2 ** D;

  logic [3:0] sb    [N];
  logic [3:0] lin   [N];
  logic [3:0] pi_o  [N];
  logic [3:0] pp_o  [N];
  logic [3:0] phi_o [N];

  // S-box layer: S1 where the select bit is set, S0 otherwise
  always_comb begin
    sb = '{default: '0};
    for (int unsigned i = 0; i < N; i++) begin
      sb[i] = sel[N-1-i] ? S1_TAB[din[4*(N-1-i) +: 4]]
                         : S0_TAB[din[4*(N-1-i) +: 4]];
    end
  end

  // Linear layer on pairs (A,B): B' = B ^ 2A, then A' = A ^ 2B'
  always_comb begin
    lin = '{default: '0};
    for (int unsigned i = 0; i < N/2; i++) begin
      lin[2*i+1] = sb[2*i+1] ^ gf_mul2(sb[2*i]);
      lin[2*i]   = sb[2*i]   ^ gf_mul2(lin[2*i+1]);
    end
  end

  // Nibble permutation P_D: pi swaps the last two of every group of four,
  // P' splits even/odd positions into halves, phi swaps pairs in the upper half
  always_comb begin
    pi_o  = '{default: '0};
    pp_o  = '{default: '0};
    phi_o = '{default: '0};
    for (int unsigned i = 0; i < N/4; i++) begin
      pi_o[4*i]   = lin[4*i];
      pi_o[4*i+1] = lin[4*i+1];
      pi_o[4*i+2] = lin[4*i+3];
      pi_o[4*i+3] = lin[4*i+2];
    end
    for (int unsigned i = 0; i < N/2; i++) begin
      pp_o[i]       = pi_o[2*i];
      pp_o[i + N/2] = pi_o[2*i+1];
    end
    for (int unsigned i = 0; i < N/2; i++) begin
      phi_o[i] = pp_o[i];
    end
    for (int unsigned i = N/4; i < N/2; i++) begin
      phi_o[2*i]   = pp_o[2*i+1];
      phi_o[2*i+1] = pp_o[2*i];
    end
  end

  // Repack nibbles, nibble 0 at the MSBs
  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < N; i++) begin
      dout[4*(N-1-i) +: 4] = phi_o[i];
    end
  end

endmodule

// File: rtl/jh_perm_iter.sv
// Iterative JH permutation E_D: accepts a grouped state and initial round
// constant, applies ROUNDS rounds at UNROLL rounds per clock while evolving
// the constant on chip, then holds the result until out_ready.
// Optional feature: define JH_PERM_ABORT_EN to add an abort input that
// returns the engine to idle with a cleared state.
module jh_perm_iter
  import jh_pkg::*;
#(
  parameter int D      = 6,
  parameter int ROUNDS = 6 * (D - 1),
  parameter int UNROLL = 1
)
(
  input  logic           clk,
  input  logic           rst_n,
  jh_perm_iter_if.slave  bus
);

  localparam int W     = state_w(D);
  localparam int CW    = const_w(D);
  localparam int CNT_W = $clog2(ROUNDS + 1);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - UNROLL);
  localparam logic [CNT_W-1:0] STEP     = CNT_W'(UNROLL);

  if (D < 4 || D > 8 || (ROUNDS % UNROLL) != 0) begin : g_param_check
    $error("jh_perm_iter: D must be 4..8 and UNROLL must divide ROUNDS");
  end

  perm_state_t   st_q, st_d;
  logic [W-1:0]  state_q;
  logic [CW-1:0] rc_q;
  logic [CNT_W-1:0] cnt_q;
  logic          abort_req;

  logic [W-1:0]  s_chain [UNROLL+1];
  logic [CW-1:0] c_chain [UNROLL+1];

  assign s_chain[0] = state_q;
  assign c_chain[0] = rc_q;

  // UNROLL data rounds chained in one cycle; the constant runs alongside as
  // an S0-only round of dimension D-2 (2^D bits = 2^(D-2) nibbles)
  for (genvar u = 0; u < UNROLL; u++) begin : g_unroll
    jh_round_core #(.D(D)) u_state_round (
      .sel  (c_chain[u]),
      .din  (s_chain[u]),
      .dout (s_chain[u+1])
    );
    jh_round_core #(.D(D - 2)) u_const_round (
      .sel  ('0),
      .din  (c_chain[u]),
      .dout (c_chain[u+1])
    );
  end

`ifdef JH_PERM_ABORT_EN
  assign abort_req = bus.abort && (st_q != PERM_IDLE);
`else
  assign abort_req = 1'b0;
`endif

  // Call lifecycle: accept in idle, iterate while busy, hold result until taken
  always_comb begin
    st_d = st_q;
    case (st_q)
      PERM_IDLE: if (bus.in_valid)     st_d = PERM_BUSY;
      PERM_BUSY: if (cnt_q == LAST_CNT) st_d = PERM_DONE;
      PERM_DONE: if (bus.out_ready)    st_d = PERM_IDLE;
      default:                         st_d = PERM_IDLE;
    endcase
    if (abort_req) begin
      st_d = PERM_IDLE;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= PERM_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  // State, constant and round-count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      rc_q    <= '0;
      cnt_q   <= '0;
    end else if (abort_req) begin
      state_q <= '0;
      rc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (st_q)
        PERM_IDLE: begin
          if (bus.in_valid) begin
            state_q <= bus.in_state;
            rc_q    <= bus.in_rc0;
            cnt_q   <= '0;
          end
        end
        PERM_BUSY: begin
          state_q <= s_chain[UNROLL];
          rc_q    <= c_chain[UNROLL];
          cnt_q   <= cnt_q + STEP;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (st_q == PERM_IDLE);
  assign bus.out_valid = (st_q == PERM_DONE);
  assign bus.out_state = state_q;

endmodule

// File: tb/tb_jh_perm_iter.sv
// Self-checking bench for jh_perm_iter. Four engines run side by side
// (D=6 one round; D=6 UNROLL=2; D=8 UNROLL=3; D=8 UNROLL=1) against a
// nibble-array model of E_D, with a per-cycle handshake/result compare.
module tb_jh_perm_iter;
  import jh_pkg::JH8_C0;

  localparam int NI = 4;
  localparam int MD [NI] = '{6, 6, 8, 8};
  localparam int MR [NI] = '{1, 30, 42, 42};
  localparam int MU [NI] = '{1, 2, 3, 1};

  typedef bit [3:0] nib_t [256];

  localparam bit [3:0] T0 [16] = '{4'h9, 4'h0, 4'h4, 4'hB, 4'hD, 4'hC, 4'h3, 4'hF,
                                   4'h1, 4'hA, 4'h2, 4'h6, 4'h7, 4'h5, 4'h8, 4'hE};
  localparam bit [3:0] T1 [16] = '{4'h3, 4'hC, 4'h6, 4'hD, 4'h5, 4'h7, 4'h1, 4'h9,
                                   4'hF, 4'h2, 4'h0, 4'h4, 4'hB, 4'hA, 4'hE, 4'h8};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic           iv  [NI];
  logic           orr [NI];
  logic           ab  [NI];
  logic [1023:0]  ist [NI];
  logic [255:0]   irc [NI];
  logic [1023:0]  dout [NI];
  logic           dov [NI];
  logic           dir [NI];

  jh_perm_iter_if #(.D(6)) if0 ();
  jh_perm_iter_if #(.D(6)) if1 ();
  jh_perm_iter_if #(.D(8)) if2 ();
  jh_perm_iter_if #(.D(8)) if3 ();

  assign if0.in_valid = iv[0];  assign if0.out_ready = orr[0];
  assign if0.in_state = ist[0][255:0];  assign if0.in_rc0 = irc[0][63:0];
  assign dout[0] = {768'b0, if0.out_state};  assign dov[0] = if0.out_valid;  assign dir[0] = if0.in_ready;

  assign if1.in_valid = iv[1];  assign if1.out_ready = orr[1];
  assign if1.in_state = ist[1][255:0];  assign if1.in_rc0 = irc[1][63:0];
  assign dout[1] = {768'b0, if1.out_state};  assign dov[1] = if1.out_valid;  assign dir[1] = if1.in_ready;

  assign if2.in_valid = iv[2];  assign if2.out_ready = orr[2];
  assign if2.in_state = ist[2];  assign if2.in_rc0 = irc[2];
  assign dout[2] = if2.out_state;  assign dov[2] = if2.out_valid;  assign dir[2] = if2.in_ready;

  assign if3.in_valid = iv[3];  assign if3.out_ready = orr[3];
  assign if3.in_state = ist[3];  assign if3.in_rc0 = irc[3];
  assign dout[3] = if3.out_state;  assign dov[3] = if3.out_valid;  assign dir[3] = if3.in_ready;

`ifdef JH_PERM_ABORT_EN
  assign if0.abort = ab[0];
  assign if1.abort = ab[1];
  assign if2.abort = ab[2];
  assign if3.abort = ab[3];
`endif

  jh_perm_iter #(.D(6), .ROUNDS(1),  .UNROLL(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  jh_perm_iter #(.D(6), .ROUNDS(30), .UNROLL(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  jh_perm_iter #(.D(8), .ROUNDS(42), .UNROLL(3)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  jh_perm_iter #(.D(8), .ROUNDS(42), .UNROLL(1)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  // ---------------- reference model ----------------
  function automatic bit [3:0] gm2(input bit [3:0] x);
    bit [4:0] p;
    p = {x, 1'b0};
    if (p[4]) p = p ^ 5'b10011;
    return p[3:0];
  endfunction

  function automatic nib_t lin_perm(input nib_t a, input int n);
    nib_t t, u;
    t = a;
    for (int i = 0; i < n/2; i++) begin
      t[2*i+1] = a[2*i+1] ^ gm2(a[2*i]);
      t[2*i]   = a[2*i]   ^ gm2(t[2*i+1]);
    end
    u = t;
    for (int i = 0; i < n/4; i++) begin
      u[4*i+2] = t[4*i+3];
      u[4*i+3] = t[4*i+2];
    end
    for (int i = 0; i < n/2; i++) begin
      t[i]       = u[2*i];
      t[i + n/2] = u[2*i+1];
    end
    u = t;
    for (int i = n/4; i < n/2; i++) begin
      u[2*i]   = t[2*i+1];
      u[2*i+1] = t[2*i];
    end
    return u;
  endfunction

  function automatic logic [1023:0] model_perm(input int d, input int rounds,
                                               input logic [1023:0] st, input logic [255:0] c0);
    int n = 1 << d;
    int nc = n / 4;
    nib_t a, c;
    logic [1023:0] r = '0;
    a = '{default: 4'h0};
    c = '{default: 4'h0};
    for (int k = 0; k < n; k++)  a[k] = st[4*(n-1-k) +: 4];
    for (int k = 0; k < nc; k++) c[k] = c0[4*(nc-1-k) +: 4];
    for (int rr = 0; rr < rounds; rr++) begin
      for (int k = 0; k < n; k++) a[k] = c[k/4][3 - k%4] ? T1[a[k]] : T0[a[k]];
      a = lin_perm(a, n);
      for (int k = 0; k < nc; k++) c[k] = T0[c[k]];
      c = lin_perm(c, nc);
    end
    for (int k = 0; k < n; k++) r[4*(n-1-k) +: 4] = a[k];
    return r;
  endfunction

  function automatic logic [1023:0] rnd1024();
    logic [1023:0] v;
    for (int j = 0; j < 32; j++) v[32*j +: 32] = $urandom();
    return v;
  endfunction

  task automatic check(input int k, input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    int w = 0;
    checks++;
    if (act !== exp) begin
      errors++;
      for (int j = 15; j >= 0; j--) if (act[64*j +: 64] !== exp[64*j +: 64]) w = j;
      $display("FAIL %s inst %0d word %0d: actual %h required %h", nm, k, w, act[64*w +: 64], exp[64*w +: 64]);
    end
  endtask

  // Per-instance phase: 0 idle, 1 busy, 2 holding result
  int            ph    [NI];
  int            left  [NI];
  logic [1023:0] exp_q [NI];
  bit            clr   [NI];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NI; k++) begin
        ph[k] <= 0; left[k] <= 0; clr[k] <= 1'b1;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        if (ab[k] && ph[k] != 0) begin
          ph[k] <= 0; clr[k] <= 1'b1;
        end else begin
          case (ph[k])
            0: if (iv[k]) begin
                 exp_q[k] <= model_perm(MD[k], MR[k], ist[k], irc[k]);
                 left[k]  <= MR[k] / MU[k] - 1;
                 ph[k]    <= 1;
                 clr[k]   <= 1'b0;
               end
            1: if (left[k] == 0) ph[k] <= 2; else left[k] <= left[k] - 1;
            default: if (orr[k]) ph[k] <= 0;
          endcase
        end
      end
    end
  end

  // Compare every engine against the model once per cycle
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NI; k++) begin
        check(k, "in_ready",  1024'(dir[k]), 1024'(ph[k] == 0));
        check(k, "out_valid", 1024'(dov[k]), 1024'(ph[k] == 2));
        if (ph[k] == 2) check(k, "out_state", dout[k], exp_q[k]);
        if (ph[k] == 0 && clr[k]) check(k, "out_state_cleared", dout[k], '0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_call(input int k, input logic [1023:0] st, input logic [255:0] rc,
                         input int hold, input bit pulse, output logic [1023:0] got);
    int n;
    @(negedge clk);
    ist[k] = st; irc[k] = rc; iv[k] = 1'b1;
    @(negedge clk);
    iv[k] = 1'b0;
    n = 1;
    while (!dov[k] && n < 400) begin
      @(negedge clk);
      n++;
    end
    got = dout[k];
    checks++;
    if (!dov[k] || (n - 1) != MR[k] / MU[k]) begin
      errors++;
      $display("FAIL latency inst %0d: actual %0d cycles required %0d", k, n - 1, MR[k] / MU[k]);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (pulse && i == hold / 2) begin
        ist[k] = ~st; iv[k] = 1'b1;
      end else begin
        iv[k] = 1'b0;
      end
    end
    orr[k] = 1'b1;
    iv[k]  = pulse;
    @(negedge clk);
    orr[k] = 1'b0;
    iv[k]  = 1'b0;
  endtask

  logic [1023:0] g0, g2, g3, rs;
  logic [255:0]  rc;

  initial begin
    for (int k = 0; k < NI; k++) begin
      iv[k] = 1'b0; orr[k] = 1'b0; ab[k] = 1'b0; ist[k] = '0; irc[k] = '0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #12;
    for (int k = 0; k < NI; k++) begin
      check(k, "reset_in_ready",  1024'(dir[k]), 1024'(1));
      check(k, "reset_out_valid", 1024'(dov[k]), 1024'(0));
      check(k, "reset_out_state", dout[k], '0);
    end
    #9 rst_n = 1'b1;

    // Model pinned against hand-derived single-round results
    check(-1, "model_pin_s0", model_perm(6, 1, '0, '0), {768'b0, {32{8'hA8}}});
    check(-1, "model_pin_s1", model_perm(6, 1, '0, '1), {768'b0, {32{8'h95}}});

    // One-round engine: all-S0 and all-S1 selections on a zero state
    do_call(0, '0, '0, 0, 1'b0, g0);
    check(0, "one_round_s0", g0, {768'b0, {32{8'hA8}}});
    do_call(0, '0, '1, 1, 1'b0, g0);
    check(0, "one_round_s1", g0, {768'b0, {32{8'h95}}});

    // D=8 E8 vector on UNROLL=3 and UNROLL=1, then a random vector on both
    fork
      do_call(2, '0, JH8_C0, 2, 1'b0, g2);
      do_call(3, '0, JH8_C0, 0, 1'b0, g3);
    join
    check(2, "e8_unroll3_vs_unroll1", g2, g3);
    rs = rnd1024();
    rc = rnd1024()[255:0];
    fork
      do_call(2, rs, rc, 0, 1'b0, g2);
      do_call(3, rs, rc, 1, 1'b0, g3);
    join
    check(2, "rand_unroll3_vs_unroll1", g2, g3);

    // Random traffic with random result backpressure
    for (int t = 0; t < 6; t++) begin
      do_call(1, rnd1024(), rnd1024()[255:0], int'($urandom_range(3, 0)), 1'b0, g0);
    end

    // Ten-cycle stall with an in_valid pulse, released with in_valid high
    do_call(1, rnd1024(), rnd1024()[255:0], 10, 1'b1, g0);
    repeat (2) @(negedge clk);

    // Reset in the middle of a call
    ist[1] = rnd1024(); irc[1] = rnd1024()[255:0]; iv[1] = 1'b1;
    @(negedge clk);
    iv[1] = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      check(k, "async_reset_in_ready",  1024'(dir[k]), 1024'(1));
      check(k, "async_reset_out_valid", 1024'(dov[k]), 1024'(0));
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    do_call(1, rnd1024(), rnd1024()[255:0], 1, 1'b0, g0);
    do_call(2, '0, JH8_C0, 0, 1'b0, g2);

`ifdef JH_PERM_ABORT_EN
    // Abort during busy, then a normal call
    @(negedge clk);
    ist[1] = rnd1024(); irc[1] = rnd1024()[255:0]; iv[1] = 1'b1;
    @(negedge clk);
    iv[1] = 1'b0;
    repeat (2) @(negedge clk);
    ab[1] = 1'b1;
    @(negedge clk);
    ab[1] = 1'b0;
    check(1, "abort_in_ready", 1024'(dir[1]), 1024'(1));
    repeat (20) @(negedge clk);
    do_call(1, rnd1024(), rnd1024()[255:0], 2, 1'b0, g0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
